// File: rtl/dma_sram_icb_slave.sv
// ICB responder fronting a word-addressed SRAM; byte-masked writes, synchronous reads,
// in-order responses through a 2-entry FIFO so one command per cycle can stream.
module dma_sram_icb_slave #(
   parameter int unsigned     AW        = 32,
   parameter int unsigned     DW        = 32,
   parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
   parameter int unsigned     DEPTH     = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sram_icb_cmd_valid,
   output logic            sram_icb_cmd_ready,
   input  logic [AW-1:0]   sram_icb_cmd_addr,
   input  logic            sram_icb_cmd_read,
   input  logic [DW-1:0]   sram_icb_cmd_wdata,
   input  logic [DW/8-1:0] sram_icb_cmd_wmask,
   output logic            sram_icb_rsp_valid,
   input  logic            sram_icb_rsp_ready,
   output logic            sram_icb_rsp_err,
   output logic [DW-1:0]   sram_icb_rsp_rdata,
   output logic            sram_busy
);

   localparam int unsigned   MW   = DW / 8;
   localparam int unsigned   IW   = $clog2(DEPTH);
   localparam logic [AW-1:0] SPAN = AW'(DEPTH * 4);

   logic [AW-1:0] off;
   logic [IW-1:0] idx;
   logic          hit;
   logic          push;
   logic          pop;

   logic [1:0]    count_q, count_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    err_q, err_d;
   logic [DW-1:0] rdata_q [2];
   logic [DW-1:0] mem [DEPTH];

   assign off = sram_icb_cmd_addr - BASE_ADDR;
   assign idx = off[IW+1:2];
   assign hit = (sram_icb_cmd_addr >= BASE_ADDR) && (off < SPAN) &&
                (sram_icb_cmd_addr[1:0] == 2'b00);

   assign sram_icb_cmd_ready = (count_q < 2'd2);
   assign sram_icb_rsp_valid = (count_q != 2'd0);
   assign sram_icb_rsp_err   = sram_icb_rsp_valid & err_q[rd_ptr_q];
   assign sram_icb_rsp_rdata = sram_icb_rsp_valid ? rdata_q[rd_ptr_q] : '0;
   assign sram_busy          = sram_icb_rsp_valid;

   assign push = sram_icb_cmd_valid && sram_icb_cmd_ready;
   assign pop  = sram_icb_rsp_valid && sram_icb_rsp_ready;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      if (push) begin
         err_d[wr_ptr_q] = !hit;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         err_q    <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Array and FIFO data are never cleared; rst_n only blocks a write in a reset cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n && push) begin
         rdata_q[wr_ptr_q] <= (hit && sram_icb_cmd_read) ? mem[idx] : '0;
         if (hit && !sram_icb_cmd_read) begin
            for (int unsigned i = 0; i < MW; i++) begin
               if (sram_icb_cmd_wmask[i]) begin
                  mem[idx][8*i +: 8] <= sram_icb_cmd_wdata[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dma_sram_icb_slave.sv
// Scoreboard bench for dma_sram_icb_slave: the driver queues expected responses on
// acceptance, an independent monitor pops and compares each consumed response.
module tb_dma_sram_icb_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_read;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        busy;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   dma_sram_icb_slave #(
      .AW(32),
      .DW(32),
      .BASE_ADDR(32'h8000_0000),
      .DEPTH(1024)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .sram_icb_cmd_valid(cmd_valid),
      .sram_icb_cmd_ready(cmd_ready),
      .sram_icb_cmd_addr(cmd_addr),
      .sram_icb_cmd_read(cmd_read),
      .sram_icb_cmd_wdata(cmd_wdata),
      .sram_icb_cmd_wmask(cmd_wmask),
      .sram_icb_rsp_valid(rsp_valid),
      .sram_icb_rsp_ready(rsp_ready),
      .sram_icb_rsp_err(rsp_err),
      .sram_icb_rsp_rdata(rsp_rdata),
      .sram_busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response the DUT hands over is matched against the queue head.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got err=%b rdata=%h expected no response", rsp_err, rsp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
            check({e.name, "_rdata"}, rsp_rdata, e.rdata);
         end
      end
   end

   task automatic issue(input string name, input logic [31:0] addr, input logic rd,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        output int unsigned acc);
      bit ok = 0;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_read  = rd;
      cmd_wdata = wdata;
      cmd_wmask = wmask;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (cmd_ready) begin
            exp_t e;
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.name  = name;
            exp_q.push_back(e);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      acc = cyc;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: got no acceptance expected acceptance within 50 cycles", name);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0 || rsp_valid) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      int unsigned acc, prev, raise;
      logic [31:0] words [4];
      words[0] = 32'h1111_1111;
      words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333;
      words[3] = 32'h4444_4444;

      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_read  = 1'b0;
      cmd_wdata = '0;
      cmd_wmask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue("wr10", 32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, acc);
      check("wr_latency_valid", {31'd0, rsp_valid}, 32'd1);
      issue("rd10", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, acc);
      check("rd_latency_valid", {31'd0, rsp_valid}, 32'd1);

      issue("wr10_part", 32'h8000_0010, 1'b0, 32'h1122_3344, 4'b0101, 1'b0, 32'h0, acc);
      issue("rd10_part", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, acc);

      for (int i = 0; i < 4; i++)
         issue($sformatf("fill%0d", i), 32'h8000_0000 + 32'(i * 4), 1'b0, words[i], 4'hF, 1'b0, 32'h0, acc);
      prev = acc;
      for (int i = 0; i < 4; i++) begin
         issue($sformatf("b2b%0d", i), 32'h8000_0000 + 32'(i * 4), 1'b1, 32'h0, 4'h0, 1'b0, words[i], acc);
         check($sformatf("b2b%0d_cycle", i), acc, prev + 1);
         prev = acc;
      end
      drain();

      rsp_ready = 1'b0;
      issue("bp0", 32'h8000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111, acc);
      issue("bp1", 32'h8000_0004, 1'b1, 32'h0, 4'h0, 1'b0, 32'h2222_2222, acc);
      check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("full_head", rsp_rdata, 32'h1111_1111);
      repeat (3) @(posedge clk);
      #1;
      check("full_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("full_hold_head", rsp_rdata, 32'h1111_1111);
      fork
         issue("bp2", 32'h8000_0008, 1'b1, 32'h0, 4'h0, 1'b0, 32'h3333_3333, acc);
         begin
            rsp_ready = 1'b1;
            raise = cyc;
         end
      join
      check("bp2_accept_cycle", acc, raise + 2);
      drain();

      issue("err_below", 32'h7FFF_FFFC, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, acc);
      issue("err_above_wr", 32'h8000_1000, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, acc);
      issue("rd0_unchanged", 32'h8000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111, acc);
      issue("err_misalign", 32'h8000_0002, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, acc);
      issue("wr_last", 32'h8000_0FFC, 1'b0, 32'h0A0B_0C0D, 4'hF, 1'b0, 32'h0, acc);
      issue("rd_last", 32'h8000_0FFC, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0A0B_0C0D, acc);
      drain();

      rsp_ready = 1'b0;
      issue("pre_rst0", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, acc);
      issue("pre_rst1", 32'h8000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111, acc);
      check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      issue("post_rst10", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, acc);
      issue("post_rst_last", 32'h8000_0FFC, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0A0B_0C0D, acc);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
